// File: rtl/mac_neuron_feeder_if.sv
// Bundle of all host-side and neuron-side signals of mac_neuron_feeder.
// master = environment (host plus neuron), slave = the feeder itself.
//
// Handshakes (valid/ready): a transfer happens on a rising clk edge where
// both valid and ready are high. cmd_valid/cmd_ready: the command is taken
// only in IDLE, a command offered while cmd_ready is low is dropped, not
// queued. res_valid/res_ready: once res_valid rises, res_acc/res_relu/err
// stay stable until the edge where res_ready is also high.
interface mac_neuron_feeder_if #(
  parameter int AW = 2
);
  logic              ld_en;
  logic              ld_sel;
  logic [AW-1:0]     ld_addr;
  logic signed [7:0] ld_data;

  logic              cmd_valid;
  logic              cmd_ready;
  logic              busy;

  logic               start_o;
  logic signed [7:0]  x_o;
  logic signed [7:0]  w_o;
  logic signed [15:0] acc_i;
  logic signed [15:0] relu_i;
  logic               done_i;

  logic               res_valid;
  logic               res_ready;
  logic signed [15:0] res_acc;
  logic signed [15:0] res_relu;
  logic               err;

  modport master (
    output ld_en, ld_sel, ld_addr, ld_data, cmd_valid,
    output acc_i, relu_i, done_i, res_ready,
    input  cmd_ready, busy, start_o, x_o, w_o,
    input  res_valid, res_acc, res_relu, err
  );

  modport slave (
    input  ld_en, ld_sel, ld_addr, ld_data, cmd_valid,
    input  acc_i, relu_i, done_i, res_ready,
    output cmd_ready, busy, start_o, x_o, w_o,
    output res_valid, res_acc, res_relu, err
  );
endinterface

// File: rtl/mac_neuron_feeder.sv
// Operand sequencer for a mac_neuron_fsm: buffers N_TERMS x/w pairs, pulses
// start, streams the pairs after a one-cycle gap, waits for done and holds
// the captured acc/relu behind a valid/ready handshake.
// Optional macro FEEDER_TIMEOUT_EN: bounded wait for done (TIMEOUT_CYCLES),
// ending in a zero result with err set.
module mac_neuron_feeder #(
  parameter int N_TERMS        = 3,
  parameter int AW             = (N_TERMS > 1) ? $clog2(N_TERMS) : 1,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic               clk,
  input  logic               rst,
  mac_neuron_feeder_if.slave bus,
  output logic [2:0]         dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_START     = 3'd1,
    S_GAP       = 3'd2,
    S_STREAM    = 3'd3,
    S_WAIT_DONE = 3'd4,
    S_RESULT    = 3'd5
  } state_t;

  state_t             state, state_nx;
  logic [AW-1:0]      k, k_nx;
  logic signed [7:0]  xbuf [N_TERMS];
  logic signed [7:0]  wbuf [N_TERMS];
  logic signed [15:0] res_acc_q, res_relu_q;
  logic signed [15:0] cap_acc, cap_relu;
  logic               capture;
  logic               load_ok;

`ifdef FEEDER_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] cnt, cnt_nx;
  logic          err_q;
  logic          err_set;
`endif

  // Next-state, stream index and result-capture decode
  always_comb begin
    state_nx = state;
    k_nx     = k;
    capture  = 1'b0;
    cap_acc  = bus.acc_i;
    cap_relu = bus.relu_i;
`ifdef FEEDER_TIMEOUT_EN
    cnt_nx   = '0;
    err_set  = 1'b0;
`endif
    case (state)
      S_IDLE:  if (bus.cmd_valid) state_nx = S_START;
      S_START: state_nx = S_GAP;
      S_GAP: begin
        state_nx = S_STREAM;
        k_nx     = '0;
      end
      S_STREAM: begin
        if (k == AW'(N_TERMS - 1)) begin
          state_nx = S_WAIT_DONE;
          k_nx     = '0;
        end else begin
          k_nx = k + 1'b1;
        end
      end
      S_WAIT_DONE: begin
        if (bus.done_i) begin
          capture  = 1'b1;
          state_nx = S_RESULT;
        end
`ifdef FEEDER_TIMEOUT_EN
        // done in the same cycle as the limit takes priority above
        else if (cnt == TW'(TIMEOUT_CYCLES - 1)) begin
          capture  = 1'b1;
          cap_acc  = '0;
          cap_relu = '0;
          err_set  = 1'b1;
          state_nx = S_RESULT;
        end else begin
          cnt_nx = cnt + 1'b1;
        end
`endif
      end
      S_RESULT: if (bus.res_ready) state_nx = S_IDLE;
      default:  state_nx = S_IDLE;
    endcase
  end

  // State register, stream index and wait counter
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S_IDLE;
      k     <= '0;
`ifdef FEEDER_TIMEOUT_EN
      cnt   <= '0;
`endif
    end else begin
      state <= state_nx;
      k     <= k_nx;
`ifdef FEEDER_TIMEOUT_EN
      cnt   <= cnt_nx;
`endif
    end
  end

  // Loads only land while idle and in range; the buffers are read in STREAM,
  // so a load in the command cycle is already visible to that evaluation.
  assign load_ok = (state == S_IDLE) && bus.ld_en && (int'(bus.ld_addr) < N_TERMS);

  // Operand buffers, kept across evaluations
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < N_TERMS; i++) begin
        xbuf[i] <= '0;
        wbuf[i] <= '0;
      end
    end else if (load_ok) begin
      if (bus.ld_sel) wbuf[bus.ld_addr] <= bus.ld_data;
      else            xbuf[bus.ld_addr] <= bus.ld_data;
    end
  end

  // Result register, frozen outside the capture edge
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      res_acc_q  <= '0;
      res_relu_q <= '0;
    end else if (capture) begin
      res_acc_q  <= cap_acc;
      res_relu_q <= cap_relu;
    end
  end

`ifdef FEEDER_TIMEOUT_EN
  // Timeout flag, cleared by the result handshake
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err_q <= 1'b0;
    end else if (capture) begin
      err_q <= err_set;
    end else if (state == S_RESULT && bus.res_ready) begin
      err_q <= 1'b0;
    end
  end
  assign bus.err = err_q;
`else
  assign bus.err = 1'b0;
`endif

  // Outputs decode straight from state so reset clears them immediately
  assign bus.cmd_ready = (state == S_IDLE);
  assign bus.busy      = (state != S_IDLE);
  assign bus.start_o   = (state == S_START);
  assign bus.x_o       = (state == S_STREAM) ? xbuf[k] : 8'sd0;
  assign bus.w_o       = (state == S_STREAM) ? wbuf[k] : 8'sd0;
  assign bus.res_valid = (state == S_RESULT);
  assign bus.res_acc   = res_acc_q;
  assign bus.res_relu  = res_relu_q;
  assign dbg_state     = state;

endmodule

// File: doc/mac_neuron_feeder.md
# mac_neuron_feeder

Operand sequencer that drives a `mac_neuron_fsm` instance from the control side. It holds a small buffer of input/weight pairs loaded by a host, and on command pulses `start`. It then streams the pairs onto the neuron's `x`/`w` inputs one per cycle, waits for `done_out`, and captures `acc`/`relu_out` into a result register with a valid/ready handshake back to the host.

## Interface
Parameters:
- `N_TERMS`, default 3: pairs per neuron evaluation; ≥1.
- `AW`, default `$clog2(N_TERMS)` (min 1): load address width.
- `TIMEOUT_CYCLES`, default 64: done-wait limit; used only with `FEEDER_TIMEOUT_EN`.

Ports:
- `clk`, in, 1: single clock; all state on rising edge.
- `rst`, in, 1: asynchronous, active-low reset.
- `ld_en`, in, 1: buffer write strobe.
- `ld_sel`, in, 1: 0 = x buffer, 1 = w buffer.
- `ld_addr`, in, AW: buffer index, 0..N_TERMS-1.
- `ld_data`, in, 8 signed: value written.
- `cmd_valid`, in, 1: request one evaluation.
- `cmd_ready`, out, 1: high only in IDLE.
- `busy`, out, 1: high in any state but IDLE.
- `start_o`, out, 1: to neuron `start`.
- `x_o`, out, 8 signed: to neuron `x`.
- `w_o`, out, 8 signed: to neuron `w`.
- `acc_i`, in, 16 signed: from neuron `acc`.
- `relu_i`, in, 16 signed: from neuron `relu_out`.
- `done_i`, in, 1: from neuron `done_out`.
- `res_valid`, out, 1: result held.
- `res_ready`, in, 1: host accepts result.
- `res_acc`, out, 16 signed: captured acc.
- `res_relu`, out, 16 signed: captured relu.
- `err`, out, 1: timeout flag; constant 0 without the macro.

## Operation
- FSM states: IDLE, START, GAP, STREAM, WAIT_DONE, RESULT.
- IDLE: `cmd_valid` high → START.
- START: `start_o` = 1 for exactly one cycle → GAP.
- GAP: one cycle with `x_o`/`w_o` = 0 → STREAM. This matches the neuron's accept-after-start spacing.
- STREAM: index `k` counts 0..N_TERMS-1. `x_o` = xbuf[k], `w_o` = wbuf[k], one pair per cycle. After k = N_TERMS-1 → WAIT_DONE.
- WAIT_DONE: `x_o`/`w_o` = 0. On `done_i` high, capture `acc_i`/`relu_i` into `res_acc`/`res_relu` in the same edge → RESULT.
- RESULT: `res_valid` = 1 and is held until `res_valid && res_ready` → IDLE. Captured values stay stable while valid.
- Buffer loads are accepted only when `busy` = 0. Loads while busy are dropped.
- A load with `ld_addr` ≥ N_TERMS is dropped.
- Buffers retain contents across evaluations. A command with no loads reuses the previous operands.
- `cmd_valid` outside IDLE is ignored; no queueing.
- `done_i` seen in START, GAP or STREAM is ignored. Only WAIT_DONE samples it.
- The block does no arithmetic. All width and sign handling stays in the neuron.

## Timing
- Reset (`rst` low, asynchronous): state = IDLE, `k` = 0, buffers = 0, all outputs 0 except `cmd_ready` = 1.
- Reset asserted mid-evaluation aborts immediately. `start_o` drops the same instant, and no result is produced.
- Command accepted on edge T: `start_o` high in cycle T+1, GAP in T+2, pairs in T+3..T+2+N_TERMS.
- Earliest `res_valid` is one cycle after the `done_i` sample.
- `res_ready` already high when `res_valid` rises: handshake completes on the next edge and `cmd_ready` returns on that edge. Back-to-back minimum period is N_TERMS + 4 cycles plus neuron done latency.
- A load and a `cmd_valid` in the same IDLE cycle: the load is written and the evaluation uses the new value, because the first buffer read happens in STREAM.

## Configuration
- `FEEDER_TIMEOUT_EN` defined:
  - A counter runs in WAIT_DONE. Reaching TIMEOUT_CYCLES with no `done_i` → RESULT with `res_acc`/`res_relu` = 0 and `err` = 1.
  - `err` clears on the result handshake or reset.
  - `done_i` in the same cycle the limit is reached wins, and `err` stays 0.
- Undefined: WAIT_DONE waits indefinitely, the counter is absent, and `err` is tied 0.

## Test plan
- Positive evaluation:
  - Stimulus: load x = {2,3,4}, w = {5,6,7}, then issue a command.
  - Required response: `start_o` is a 1-cycle pulse; pairs appear in order after a 1-cycle gap; `res_acc` = 56 and `res_relu` = 56 with `res_valid` held until `res_ready`.
- Negative evaluation:
  - Stimulus: load x = {-2,-3,-4}, w = {5,6,7}, then issue a command.
  - Required response: `res_acc` = -56, `res_relu` = 0.
- Load while busy:
  - Stimulus: write x[0] = 9 during STREAM.
  - Required response: the write is dropped; a repeat command still yields acc 56 on the positive data.
- Result back-pressure and ignored command:
  - Stimulus: hold `res_ready` = 0 for 10 cycles, and pulse `cmd_valid` during that time.
  - Required response: result stays stable; the command is ignored; `cmd_ready` returns only after the handshake.
- Reset mid-STREAM:
  - Stimulus: pull `rst` low mid-STREAM.
  - Required response: all outputs reach reset values asynchronously, buffers read 0, and no `res_valid` appears.
- Timeout (with `FEEDER_TIMEOUT_EN`, TIMEOUT_CYCLES = 8):
  - Stimulus: tie `done_i` low.
  - Required response: after 8 WAIT_DONE cycles `res_valid` = 1, `err` = 1, results 0; `err` clears on handshake.
